// File: rtl/audio_addr_sequencer.sv
// Sample-address sequencer between the codec interface and the sample ROM.
// Waits for codec init, then steps Add through a latched [start..end] window once per CLK_DIV clocks.
module audio_addr_sequencer #(
  parameter int ADDR_W   = 17,
  parameter int CLK_DIV  = 126,
  parameter int AUTO_RUN = 0,
  parameter int END_DEF  = 46094
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              INIT_FINISH,
  input  logic              data_over,
  input  logic              play,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              INIT,
  output logic [ADDR_W-1:0] Add,
  output logic              busy,
  output logic              done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(CLK_DIV - 1);
  localparam logic [ADDR_W-1:0] END_DEF_A = ADDR_W'(END_DEF);

  typedef enum logic [1:0] {S_WAIT_INIT, S_IDLE, S_RUN, S_PAUSE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   add_q, add_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                loop_q, loop_d;
  logic                init_q, init_d;
  logic                done_q, done_d;
  logic                play_ok, tick, load;

  assign play_ok = play && (start_addr <= end_addr);
  assign tick    = (div_q == DIV_MAX);

  always_comb begin
    state_d = state_q;
    add_d   = add_q;
    start_d = start_q;
    end_d   = end_q;
    div_d   = div_q;
    loop_d  = loop_q;
    init_d  = 1'b1;
    done_d  = 1'b0;
    load    = 1'b0;

    case (state_q)
      S_WAIT_INIT: begin
        if (INIT_FINISH) begin
          if (AUTO_RUN != 0) begin
            state_d = S_RUN;
            add_d   = '0;
            div_d   = '0;
            start_d = '0;
            end_d   = END_DEF_A;
            loop_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        // stop outranks play even when nothing is playing
        if (!stop && play_ok) load = 1'b1;
      end
      S_RUN, S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
          add_d   = start_q;
          div_d   = '0;
        end else if (play_ok) begin
          load = 1'b1;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else begin
          // the release cycle out of PAUSE counts, so phase is preserved exactly
          state_d = S_RUN;
          if (tick) begin
            div_d = '0;
            if (data_over) begin
              if (add_q < end_q) begin
                add_d = add_q + 1'b1;
              end else begin
                done_d = 1'b1;
                add_d  = start_q;
                if (!loop_q) state_d = S_IDLE;
              end
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      default: state_d = S_WAIT_INIT;
    endcase

    if (load) begin
      state_d = S_RUN;
      add_d   = start_addr;
      div_d   = '0;
      start_d = start_addr;
      end_d   = end_addr;
      loop_d  = loop;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_WAIT_INIT;
      add_q   <= '0;
      start_q <= '0;
      end_q   <= '0;
      div_q   <= '0;
      loop_q  <= 1'b0;
      init_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      add_q   <= add_d;
      start_q <= start_d;
      end_q   <= end_d;
      div_q   <= div_d;
      loop_q  <= loop_d;
      init_q  <= init_d;
      done_q  <= done_d;
    end
  end

  assign INIT = init_q;
  assign Add  = add_q;
  assign busy = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign done = done_q;

endmodule

// File: tb/tb_audio_addr_sequencer.sv
// Bench for audio_addr_sequencer: directed scenarios plus a randomized run checked
// against a clip-level reference model; a second instance covers AUTO_RUN.
module tb_audio_addr_sequencer;

  localparam int AW      = 17;
  localparam int DIV     = 4;
  localparam int A_DIV   = 2;
  localparam int A_END   = 300;

  logic          Clk = 1'b0;
  logic          Reset, INIT_FINISH, data_over, play, stop, pause, loop;
  logic [AW-1:0] start_addr, end_addr;
  logic          INIT, busy, done;
  logic [AW-1:0] Add;

  logic          rst_a, if_a, dov_a, zero_a;
  logic [AW-1:0] zaddr_a;
  logic          init_a, busy_a, done_a;
  logic [AW-1:0] add_a;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  audio_addr_sequencer #(.ADDR_W(AW), .CLK_DIV(DIV), .AUTO_RUN(0), .END_DEF(46094)) dut (
    .Clk(Clk), .Reset(Reset), .INIT_FINISH(INIT_FINISH), .data_over(data_over),
    .play(play), .stop(stop), .pause(pause), .loop(loop),
    .start_addr(start_addr), .end_addr(end_addr),
    .INIT(INIT), .Add(Add), .busy(busy), .done(done)
  );

  audio_addr_sequencer #(.ADDR_W(AW), .CLK_DIV(A_DIV), .AUTO_RUN(1), .END_DEF(A_END)) dut_auto (
    .Clk(Clk), .Reset(rst_a), .INIT_FINISH(if_a), .data_over(dov_a),
    .play(zero_a), .stop(zero_a), .pause(zero_a), .loop(zero_a),
    .start_addr(zaddr_a), .end_addr(zaddr_a),
    .INIT(init_a), .Add(add_a), .busy(busy_a), .done(done_a)
  );

  // Clip-level model: mode 0 = waiting for codec, 1 = idle, 2 = playing (paused or not).
  int m_mode, m_add, m_start, m_end, m_phase;
  bit m_loop, m_done, m_init;

  always @(posedge Clk) begin
    if (Reset) begin
      m_mode <= 0; m_add <= 0; m_start <= 0; m_end <= 0; m_phase <= 0;
      m_loop <= 0; m_done <= 0; m_init <= 0;
    end else begin
      m_init <= 1;
      m_done <= 0;
      if (m_mode == 0) begin
        if (INIT_FINISH) m_mode <= 1;
      end else if (stop) begin
        if (m_mode == 2) begin
          m_mode <= 1; m_add <= m_start; m_phase <= 0;
        end
      end else if (play && start_addr <= end_addr) begin
        m_mode <= 2; m_add <= int'(start_addr); m_start <= int'(start_addr);
        m_end <= int'(end_addr); m_loop <= loop; m_phase <= 0;
      end else if (m_mode == 2 && !pause) begin
        if (m_phase + 1 == DIV) begin
          m_phase <= 0;
          if (data_over) begin
            if (m_add == m_end) begin
              m_done <= 1; m_add <= m_start;
              if (!m_loop) m_mode <= 1;
            end else begin
              m_add <= m_add + 1;
            end
          end
        end else begin
          m_phase <= m_phase + 1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_clip(input int s, input int e, input bit lp);
    start_addr = AW'(s); end_addr = AW'(e); loop = lp; play = 1'b1;
    cyc();
    play = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; INIT_FINISH = 1'b0;
    repeat (3) cyc();
    n_checks++;
    if (INIT !== 1'b0 || Add !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_vals INIT=%b Add=%0d busy=%b done=%b expected 0/0/0/0", INIT, Add, busy, done);
    end
    Reset = 1'b0;
    cyc();
    n_checks++;
    if (INIT !== 1'b1) begin
      n_errors++; $display("FAIL init_rise INIT=%b expected 1", INIT);
    end
    start_clip(1, 5, 0);
    repeat (3) cyc();
    n_checks++;
    if (busy !== 1'b0 || Add !== '0 || INIT !== 1'b1) begin
      n_errors++;
      $display("FAIL wait_init_hold busy=%b Add=%0d INIT=%b expected 0/0/1", busy, Add, INIT);
    end
    INIT_FINISH = 1'b1;
    cyc();
  endtask

  task automatic test_oneshot();
    int exp_add;
    data_over = 1'b1;
    start_clip(10, 13, 0);
    for (int k = 0; k <= 18; k++) begin
      if (k > 0) cyc();
      exp_add = (k < 16) ? 10 + k / 4 : 10;
      n_checks++;
      if (int'(Add) !== exp_add || done !== (k == 16) || busy !== (k < 16)) begin
        n_errors++;
        $display("FAIL oneshot k=%0d Add=%0d done=%b busy=%b expected %0d/%b/%b",
                 k, Add, done, busy, exp_add, k == 16, k < 16);
      end
    end
  endtask

  task automatic test_loop();
    int exp_add;
    start_clip(10, 13, 1);
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) cyc();
      exp_add = 10 + (k / 4) % 4;
      n_checks++;
      if (int'(Add) !== exp_add || done !== (k > 0 && k % 16 == 0) || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL loop k=%0d Add=%0d done=%b busy=%b expected %0d/%b/1",
                 k, Add, done, busy, exp_add, k > 0 && k % 16 == 0);
      end
    end
  endtask

  task automatic test_pause_dataover();
    int act, exp_add;
    start_clip(100, 120, 1);
    act = 0; exp_add = 100;
    for (int k = 1; k <= 40; k++) begin
      pause     = (k >= 6 && k <= 14);
      data_over = !(k >= 22 && k <= 25);
      cyc();
      if (!pause) begin
        act++;
        if (act % DIV == 0 && data_over) exp_add++;
      end
      n_checks++;
      if (int'(Add) !== exp_add || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL pause_dov k=%0d Add=%0d busy=%b expected %0d/1", k, Add, busy, exp_add);
      end
    end
    pause = 1'b0; data_over = 1'b1;
  endtask

  task automatic test_stop_play();
    stop = 1'b1; play = 1'b1; start_addr = AW'(30); end_addr = AW'(35); loop = 1'b0;
    cyc();
    stop = 1'b0; play = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Add !== AW'(100)) begin
      n_errors++;
      $display("FAIL stop_play busy=%b done=%b Add=%0d expected 0/0/100", busy, done, Add);
    end
    start_clip(20, 5, 0);
    repeat (5) cyc();
    n_checks++;
    if (busy !== 1'b0 || Add !== AW'(100) || done !== 1'b0) begin
      n_errors++;
      $display("FAIL bad_window busy=%b Add=%0d done=%b expected 0/100/0", busy, Add, done);
    end
  endtask

  task automatic test_boundary();
    int top, exp_add;
    top = (1 << AW) - 1;
    start_clip(top - 2, top, 1);
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) cyc();
      exp_add = top - 2 + (k / 4) % 3;
      n_checks++;
      if (int'(Add) !== exp_add || done !== (k == 12)) begin
        n_errors++;
        $display("FAIL boundary k=%0d Add=%0d done=%b expected %0d/%b", k, Add, done, exp_add, k == 12);
      end
    end
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic test_reset_midrun();
    start_clip(0, 50, 0);
    repeat (10) cyc();
    Reset = 1'b1;
    cyc();
    n_checks++;
    if (Add !== '0 || busy !== 1'b0 || INIT !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_midrun Add=%0d busy=%b INIT=%b done=%b expected 0/0/0/0", Add, busy, INIT, done);
    end
    Reset = 1'b0; INIT_FINISH = 1'b0;
    start_clip(2, 9, 0);
    cyc();
    n_checks++;
    if (busy !== 1'b0 || INIT !== 1'b1) begin
      n_errors++; $display("FAIL rerun_wait busy=%b INIT=%b expected 0/1", busy, INIT);
    end
    INIT_FINISH = 1'b1;
    cyc();
  endtask

  task automatic test_random();
    int s;
    for (int k = 0; k < 3000; k++) begin
      Reset       = ($urandom_range(0, 499) == 0);
      INIT_FINISH = ($urandom_range(0, 9) != 0);
      data_over   = ($urandom_range(0, 4) != 0);
      play        = ($urandom_range(0, 39) == 0);
      stop        = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      loop        = $urandom_range(0, 1);
      s           = $urandom_range(2, 40);
      start_addr  = AW'(s);
      end_addr    = AW'(s + $urandom_range(0, 8) - 2);
      cyc();
      n_checks++;
      if (int'(Add) !== m_add || busy !== (m_mode == 2) || done !== m_done || INIT !== m_init) begin
        n_errors++;
        $display("FAIL random k=%0d Add=%0d busy=%b done=%b INIT=%b expected %0d/%b/%b/%b",
                 k, Add, busy, done, INIT, m_add, m_mode == 2, m_done, m_init);
      end
    end
    Reset = 1'b0; play = 1'b0; stop = 1'b0; pause = 1'b0; INIT_FINISH = 1'b1;
  endtask

  task automatic test_auto();
    int n, prev;
    bit seen;
    rst_a = 1'b1; if_a = 1'b1;
    cyc();
    rst_a = 1'b0;
    cyc();
    n_checks++;
    if (busy_a !== 1'b1 || add_a !== '0) begin
      n_errors++; $display("FAIL auto_start busy=%b Add=%0d expected 1/0", busy_a, add_a);
    end
    n = 0; seen = 0; prev = 0;
    while (!seen && n < 2000) begin
      prev = int'(add_a);
      cyc();
      n++;
      seen = done_a;
    end
    n_checks++;
    if (!seen || n != (A_END + 1) * A_DIV || prev != A_END || add_a !== '0 || busy_a !== 1'b1) begin
      n_errors++;
      $display("FAIL auto_wrap seen=%b cycles=%0d prev=%0d Add=%0d busy=%b expected 1/%0d/%0d/0/1",
               seen, n, prev, add_a, busy_a, (A_END + 1) * A_DIV, A_END);
    end
    repeat (7) cyc();
    rst_a = 1'b1;
    cyc();
    rst_a = 1'b0; if_a = 1'b0;
    n_checks++;
    if (add_a !== '0 || busy_a !== 1'b0 || init_a !== 1'b0) begin
      n_errors++; $display("FAIL auto_reset Add=%0d busy=%b INIT=%b expected 0/0/0", add_a, busy_a, init_a);
    end
    repeat (4) cyc();
    n_checks++;
    if (busy_a !== 1'b0 || add_a !== '0 || init_a !== 1'b1) begin
      n_errors++; $display("FAIL auto_wait busy=%b Add=%0d INIT=%b expected 0/0/1", busy_a, add_a, init_a);
    end
  endtask

  initial begin
    Reset = 1'b1; INIT_FINISH = 1'b0; data_over = 1'b1; play = 1'b0; stop = 1'b0;
    pause = 1'b0; loop = 1'b0; start_addr = '0; end_addr = '0;
    rst_a = 1'b1; if_a = 1'b0; dov_a = 1'b1; zero_a = 1'b0; zaddr_a = '0;
    test_reset();
    test_oneshot();
    test_loop();
    test_pause_dataover();
    test_stop_play();
    test_boundary();
    test_reset_midrun();
    test_random();
    test_auto();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
